// File: rtl/wb_commit_unit.sv
// wb_commit_unit: multi-lane writeback / commit stage.
// Accepts a bundle of up to LANES retired instructions per cycle, drives LANES
// register-file write ports, resolves the oldest jump/taken-branch redirect
// (squashing younger lanes), and buffers surviving lanes in a DEPTH-entry
// commit FIFO for the commit sink.
//
// Ports (per-lane fields packed with lane 0 in the LSBs):
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     bundle handshake (accept = in_ready & |in_valid)
//   in_is_wb .. in_br_taken per-lane decode flags
//   in_wd, in_alu_out, in_mem_out, in_pc_plus4, in_pc, in_instr  lane data
//   rf_we, rf_wd, rf_wdata  registered register-file write ports
//   jump_en, jump_addr      registered one-cycle redirect
//   cm_valid / cm_ready     commit FIFO head handshake
//   cm_mask, cm_is_wb, cm_wd, cm_wdata, cm_pc, cm_instr  head bundle contents
//   retired_cnt             total committed instructions
module wb_commit_unit #(
    parameter int unsigned LANES = 2,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0]        in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_is_wb,
    input  logic [LANES-1:0]        in_is_mem_read,
    input  logic [LANES-1:0]        in_is_jump,
    input  logic [LANES-1:0]        in_is_branch,
    input  logic [LANES-1:0]        in_br_taken,
    input  logic [5*LANES-1:0]      in_wd,
    input  logic [XLEN*LANES-1:0]   in_alu_out,
    input  logic [XLEN*LANES-1:0]   in_mem_out,
    input  logic [XLEN*LANES-1:0]   in_pc_plus4,
    input  logic [XLEN*LANES-1:0]   in_pc,
    input  logic [32*LANES-1:0]     in_instr,
    output logic [LANES-1:0]        rf_we,
    output logic [5*LANES-1:0]      rf_wd,
    output logic [XLEN*LANES-1:0]   rf_wdata,
    output logic                    jump_en,
    output logic [XLEN-1:0]         jump_addr,
    output logic                    cm_valid,
    input  logic                    cm_ready,
    output logic [LANES-1:0]        cm_mask,
    output logic [LANES-1:0]        cm_is_wb,
    output logic [5*LANES-1:0]      cm_wd,
    output logic [XLEN*LANES-1:0]   cm_wdata,
    output logic [XLEN*LANES-1:0]   cm_pc,
    output logic [32*LANES-1:0]     cm_instr,
    output logic [63:0]             retired_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             flush;
    logic             accept;
    logic             pop;

    logic [XLEN*LANES-1:0] wdata_c;
    logic [LANES-1:0]      survive_c;
    logic [LANES-1:0]      writes_c;
    logic [LANES-1:0]      rf_we_c;
    logic                  redirect_c;
    logic [XLEN-1:0]       target_c;

    // Commit FIFO storage; contents are don't-care out of reset.
    logic [LANES-1:0]      fifo_mask  [DEPTH];
    logic [LANES-1:0]      fifo_is_wb [DEPTH];
    logic [5*LANES-1:0]    fifo_wd    [DEPTH];
    logic [XLEN*LANES-1:0] fifo_wdata [DEPTH];
    logic [XLEN*LANES-1:0] fifo_pc    [DEPTH];
    logic [32*LANES-1:0]   fifo_instr [DEPTH];

    function automatic logic [63:0] popcount(input logic [LANES-1:0] m);
        logic [63:0] sum;
        sum = 64'd0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum = sum + 64'(m[i]);
        end
        return sum;
    endfunction

    // The cycle after a redirect is the upstream flush cycle.
    assign flush    = jump_en;
    assign in_ready = rst_n & (count < CNT_W'(DEPTH)) & ~flush;
    assign accept   = in_ready & (|in_valid);
    assign cm_valid = (count != CNT_W'(0));
    assign pop      = cm_valid & cm_ready;

    // Lane data select, oldest-lane redirect, squash and write qualification.
    always_comb begin
        wdata_c    = '0;
        survive_c  = '0;
        writes_c   = '0;
        rf_we_c    = '0;
        redirect_c = 1'b0;
        target_c   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_is_mem_read[i]) begin
                wdata_c[i*XLEN +: XLEN] = in_mem_out[i*XLEN +: XLEN];
            end else if (in_is_jump[i]) begin
                wdata_c[i*XLEN +: XLEN] = in_pc_plus4[i*XLEN +: XLEN];
            end else begin
                wdata_c[i*XLEN +: XLEN] = in_alu_out[i*XLEN +: XLEN];
            end
            // A lane survives unless an older lane already redirected.
            survive_c[i] = in_valid[i] & ~redirect_c;
            writes_c[i]  = survive_c[i] & (in_is_wb[i] | in_is_jump[i]) &
                           (in_wd[i*5 +: 5] != 5'd0);
            if (survive_c[i] & (in_is_jump[i] | (in_is_branch[i] & in_br_taken[i]))) begin
                redirect_c = 1'b1;
                target_c   = {in_alu_out[i*XLEN+1 +: XLEN-1], 1'b0};
            end
        end
        // WAW collapse: a write is dropped if any younger lane writes the same register.
        for (int unsigned i = 0; i < LANES; i++) begin
            rf_we_c[i] = writes_c[i];
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (writes_c[j] && (in_wd[j*5 +: 5] == in_wd[i*5 +: 5])) begin
                    rf_we_c[i] = 1'b0;
                end
            end
        end
    end

    // Register-file write ports and redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= '0;
            rf_wd     <= '0;
            rf_wdata  <= '0;
            jump_en   <= 1'b0;
            jump_addr <= '0;
        end else begin
            rf_we   <= accept ? rf_we_c : '0;
            jump_en <= accept & redirect_c;
            if (accept) begin
                rf_wd    <= in_wd;
                rf_wdata <= wdata_c;
            end
            if (accept & redirect_c) begin
                jump_addr <= target_c;
            end
        end
    end

    // FIFO pointers, occupancy and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            retired_cnt <= 64'd0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                retired_cnt <= retired_cnt + popcount(fifo_mask[rd_ptr]);
            end
            if (accept & ~pop) begin
                count <= count + CNT_W'(1);
            end else if (pop & ~accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mask[wr_ptr]  <= survive_c;
            fifo_is_wb[wr_ptr] <= writes_c;
            fifo_wd[wr_ptr]    <= in_wd;
            fifo_wdata[wr_ptr] <= wdata_c;
            fifo_pc[wr_ptr]    <= in_pc;
            fifo_instr[wr_ptr] <= in_instr;
        end
    end

    assign cm_mask  = fifo_mask[rd_ptr];
    assign cm_is_wb = fifo_is_wb[rd_ptr];
    assign cm_wd    = fifo_wd[rd_ptr];
    assign cm_wdata = fifo_wdata[rd_ptr];
    assign cm_pc    = fifo_pc[rd_ptr];
    assign cm_instr = fifo_instr[rd_ptr];

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit (LANES=2, XLEN=64, DEPTH=4).
module tb_wb_commit_unit;

    localparam int unsigned LANES = 2;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;

    logic                  clk;
    logic                  rst_n;
    logic [LANES-1:0]      in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      in_is_wb;
    logic [LANES-1:0]      in_is_mem_read;
    logic [LANES-1:0]      in_is_jump;
    logic [LANES-1:0]      in_is_branch;
    logic [LANES-1:0]      in_br_taken;
    logic [5*LANES-1:0]    in_wd;
    logic [XLEN*LANES-1:0] in_alu_out;
    logic [XLEN*LANES-1:0] in_mem_out;
    logic [XLEN*LANES-1:0] in_pc_plus4;
    logic [XLEN*LANES-1:0] in_pc;
    logic [32*LANES-1:0]   in_instr;
    logic [LANES-1:0]      rf_we;
    logic [5*LANES-1:0]    rf_wd;
    logic [XLEN*LANES-1:0] rf_wdata;
    logic                  jump_en;
    logic [XLEN-1:0]       jump_addr;
    logic                  cm_valid;
    logic                  cm_ready;
    logic [LANES-1:0]      cm_mask;
    logic [LANES-1:0]      cm_is_wb;
    logic [5*LANES-1:0]    cm_wd;
    logic [XLEN*LANES-1:0] cm_wdata;
    logic [XLEN*LANES-1:0] cm_pc;
    logic [32*LANES-1:0]   cm_instr;
    logic [63:0]           retired_cnt;

    int errors;
    int checks;

    wb_commit_unit #(.LANES(LANES), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_wb       (in_is_wb),
        .in_is_mem_read (in_is_mem_read),
        .in_is_jump     (in_is_jump),
        .in_is_branch   (in_is_branch),
        .in_br_taken    (in_br_taken),
        .in_wd          (in_wd),
        .in_alu_out     (in_alu_out),
        .in_mem_out     (in_mem_out),
        .in_pc_plus4    (in_pc_plus4),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .rf_we          (rf_we),
        .rf_wd          (rf_wd),
        .rf_wdata       (rf_wdata),
        .jump_en        (jump_en),
        .jump_addr      (jump_addr),
        .cm_valid       (cm_valid),
        .cm_ready       (cm_ready),
        .cm_mask        (cm_mask),
        .cm_is_wb       (cm_is_wb),
        .cm_wd          (cm_wd),
        .cm_wdata       (cm_wdata),
        .cm_pc          (cm_pc),
        .cm_instr       (cm_instr),
        .retired_cnt    (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid       = '0;
        in_is_wb       = '0;
        in_is_mem_read = '0;
        in_is_jump     = '0;
        in_is_branch   = '0;
        in_br_taken    = '0;
        in_wd          = '0;
        in_alu_out     = '0;
        in_mem_out     = '0;
        in_pc_plus4    = '0;
        in_pc          = '0;
        in_instr       = '0;
    endtask

    // flags = {valid, is_wb, is_mem_read, is_jump, is_branch, br_taken}
    task automatic set_lane(input int lane, input logic [5:0] flags, input logic [4:0] wd,
                            input logic [63:0] alu, input logic [63:0] mem,
                            input logic [63:0] pc4);
        in_valid[lane]             = flags[5];
        in_is_wb[lane]             = flags[4];
        in_is_mem_read[lane]       = flags[3];
        in_is_jump[lane]           = flags[2];
        in_is_branch[lane]         = flags[1];
        in_br_taken[lane]          = flags[0];
        in_wd[lane*5 +: 5]         = wd;
        in_alu_out[lane*64 +: 64]  = alu;
        in_mem_out[lane*64 +: 64]  = mem;
        in_pc_plus4[lane*64 +: 64] = pc4;
        in_pc[lane*64 +: 64]       = pc4 - 64'd4;
        in_instr[lane*32 +: 32]    = 32'h13 + 32'(lane);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        cm_ready = 1'b0;
        clear_in();
        step();
        step();
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_cm_valid", 64'(cm_valid), 64'd0);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_jump_en", 64'(jump_en), 64'd0);
        chk("reset_retired", retired_cnt, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Basic bundle: lane0 alu write x5, lane1 load x6.
        set_lane(0, 6'b110000, 5'd5, 64'h10, 64'h0, 64'h1004);
        set_lane(1, 6'b111000, 5'd6, 64'h0, 64'h20, 64'h1008);
        step();
        clear_in();
        chk("t1_rf_we", 64'(rf_we), 64'h3);
        chk("t1_rf_wd", 64'(rf_wd), 64'h0C5);
        chk("t1_rf_wdata0", rf_wdata[63:0], 64'h10);
        chk("t1_rf_wdata1", rf_wdata[127:64], 64'h20);
        chk("t1_jump_en", 64'(jump_en), 64'd0);
        chk("t1_cm_valid", 64'(cm_valid), 64'd1);
        chk("t1_cm_mask", 64'(cm_mask), 64'h3);
        chk("t1_cm_is_wb", 64'(cm_is_wb), 64'h3);
        chk("t1_cm_pc1", cm_pc[127:64], 64'h1004);
        step();
        chk("t1_rf_we_off", 64'(rf_we), 64'd0);
        chk("t1_cm_hold", 64'(cm_valid), 64'd1);
        cm_ready = 1'b1;
        step();
        cm_ready = 1'b0;
        chk("t1_retired", retired_cnt, 64'd2);
        chk("t1_empty", 64'(cm_valid), 64'd0);

        // Taken branch in lane0 squashes lane1.
        set_lane(0, 6'b100011, 5'd0, 64'h8000_0005, 64'h0, 64'h2004);
        set_lane(1, 6'b110000, 5'd7, 64'h77, 64'h0, 64'h2008);
        step();
        clear_in();
        chk("t2_jump_en", 64'(jump_en), 64'd1);
        chk("t2_jump_addr", jump_addr, 64'h8000_0004);
        chk("t2_rf_we", 64'(rf_we), 64'd0);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        chk("t2_cm_mask", 64'(cm_mask), 64'h1);
        chk("t2_cm_is_wb", 64'(cm_is_wb), 64'h0);
        step();
        chk("t2_jump_pulse", 64'(jump_en), 64'd0);
        chk("t2_in_ready_back", 64'(in_ready), 64'd1);
        cm_ready = 1'b1;
        step();
        cm_ready = 1'b0;
        chk("t2_retired", retired_cnt, 64'd3);

        // WAW collapse on x9.
        set_lane(0, 6'b110000, 5'd9, 64'h1, 64'h0, 64'h3004);
        set_lane(1, 6'b110000, 5'd9, 64'h2, 64'h0, 64'h3008);
        step();
        clear_in();
        chk("t3_rf_we", 64'(rf_we), 64'h2);
        chk("t3_rf_wdata1", rf_wdata[127:64], 64'h2);
        chk("t3_cm_mask", 64'(cm_mask), 64'h3);
        chk("t3_cm_is_wb", 64'(cm_is_wb), 64'h3);
        chk("t3_cm_wdata0", cm_wdata[63:0], 64'h1);
        chk("t3_cm_wdata1", cm_wdata[127:64], 64'h2);
        cm_ready = 1'b1;
        step();
        cm_ready = 1'b0;
        chk("t3_retired", retired_cnt, 64'd5);

        // Fill the FIFO with cm_ready low; pointers start at 3 so the fill wraps.
        for (int k = 0; k < 4; k++) begin
            clear_in();
            set_lane(0, 6'b110000, 5'(10 + k), 64'h100 + 64'(k), 64'h0, 64'h4004);
            chk("t4_ready_fill", 64'(in_ready), 64'd1);
            step();
        end
        chk("t4_full_ready", 64'(in_ready), 64'd0);
        step();
        chk("t4_full_hold", 64'(in_ready), 64'd0);
        chk("t4_head_kept", cm_wdata[63:0], 64'h100);
        clear_in();
        cm_ready = 1'b1;
        #1;
        chk("t4_full_cm_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain_valid", 64'(cm_valid), 64'd1);
            chk("t4_drain_wd", 64'(cm_wd[4:0]), 64'(10 + k));
            chk("t4_drain_data", cm_wdata[63:0], 64'h100 + 64'(k));
            step();
        end
        cm_ready = 1'b0;
        chk("t4_drained", 64'(cm_valid), 64'd0);
        chk("t4_retired", retired_cnt, 64'd9);

        // jal x0 in lane0 redirects; lane1 jal x1 squashed.
        set_lane(0, 6'b100100, 5'd0, 64'h201, 64'h0, 64'h104);
        set_lane(1, 6'b100100, 5'd1, 64'h301, 64'h0, 64'h104);
        step();
        clear_in();
        chk("t5_jump_en", 64'(jump_en), 64'd1);
        chk("t5_jump_addr", jump_addr, 64'h200);
        chk("t5_rf_we", 64'(rf_we), 64'd0);
        chk("t5_cm_mask", 64'(cm_mask), 64'h1);
        chk("t5_cm_is_wb", 64'(cm_is_wb), 64'h0);
        chk("t5_cm_wdata0", cm_wdata[63:0], 64'h104);
        step();

        // Build up 3 buffered bundles with jump_en high, then reset asynchronously.
        set_lane(0, 6'b110000, 5'd3, 64'h33, 64'h0, 64'h5004);
        step();
        clear_in();
        set_lane(0, 6'b100011, 5'd0, 64'h300, 64'h0, 64'h5008);
        step();
        clear_in();
        chk("t6_pre_jump", 64'(jump_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_jump_en", 64'(jump_en), 64'd0);
        chk("t6_rst_jump_addr", jump_addr, 64'd0);
        chk("t6_rst_rf_we", 64'(rf_we), 64'd0);
        chk("t6_rst_cm_valid", 64'(cm_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_retired", retired_cnt, 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_after_cm_valid", 64'(cm_valid), 64'd0);
        set_lane(0, 6'b110000, 5'd5, 64'h10, 64'h0, 64'h6004);
        set_lane(1, 6'b111000, 5'd6, 64'h0, 64'h20, 64'h6008);
        step();
        clear_in();
        chk("t6_new_rf_we", 64'(rf_we), 64'h3);
        chk("t6_new_cm_mask", 64'(cm_mask), 64'h3);
        chk("t6_new_cm_pc0", cm_pc[63:0], 64'h6000);
        cm_ready = 1'b1;
        step();
        cm_ready = 1'b0;
        chk("t6_new_retired", retired_cnt, 64'd2);
        chk("t6_new_empty", 64'(cm_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
